// File: rtl/aes_sub_pkg.sv
// Shared constants, owner encoding and beat-count helpers for the S-box scheduler.
package aes_sub_pkg;

    localparam int ST_BYTES = 16;
    localparam int KW_BYTES = 4;

    // Which requester drives the shared S-box bank in a given beat.
    typedef enum logic {
        OWN_ST,
        OWN_KW
    } own_e;

    // Number of beats needed to push a job of 'bytes' bytes through 'lanes' S-boxes.
    // A job narrower than the bank still takes one full beat.
    function automatic int beatCount(input int bytes, input int lanes);
        return (bytes > lanes) ? (bytes / lanes) : 1;
    endfunction

    // The bank width must divide the 16-byte state evenly.
    function automatic bit legalLanes(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/sbox_bank.sv
// Combinational AES S-box and a bank of LANES of them sharing one direction select.

// Single AES S-box, forward or inverse, computed as GF(2^8) inversion plus affine map.
module bSbox (
    input  logic       encrypt_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = '0;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ acc;
            acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1B : 8'h00);
        end
        return prod;
    endfunction

    // x^254 equals x^-1 in GF(2^8) and maps 0 to 0, as the S-box needs.
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] result;
        logic [7:0] sq;
        result = 8'h01;
        sq     = x;
        for (int i = 1; i < 8; i++) begin
            sq     = gfMul(sq, sq);
            result = gfMul(result, sq);
        end
        return result;
    endfunction

    function automatic logic [7:0] fwdAffine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] invAffine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    assign inv_in  = encrypt_i ? data_i : invAffine(data_i);
    assign inv_out = gfInv(inv_in);
    assign data_o  = encrypt_i ? fwdAffine(inv_out) : inv_out;

endmodule

// Bank of LANES independent S-boxes, byte i of the bus goes through lane i.
module sbox_bank #(
    parameter int LANES = 4
) (
    input  logic               encrypt_i,
    input  logic [8*LANES-1:0] data_i,
    output logic [8*LANES-1:0] data_o
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bSbox u_sbox (
            .encrypt_i (encrypt_i),
            .data_i    (data_i[8*g +: 8]),
            .data_o    (data_o[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_sub_sched.sv
// Round-robin beat scheduler sharing one S-box bank between the AES state
// (SubBytes/InvSubBytes) and the key expansion (SubWord).
module aes_sub_sched
    import aes_sub_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    input  logic         st_encrypt,
    output logic         st_done,
    output logic [127:0] st_result,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_data,
    output logic         kw_done,
    output logic [31:0]  kw_result,
    output logic         busy
);

    localparam int ST_BEATS = beatCount(ST_BYTES, LANES);
    localparam int KW_BEATS = beatCount(KW_BYTES, LANES);
    localparam int KW_LANES = (LANES > KW_BYTES) ? KW_BYTES : LANES;
    localparam int BW       = 8 * LANES;
    localparam int KW_BW    = 8 * KW_LANES;
    localparam logic [4:0] ST_LAST = 5'(ST_BEATS - 1);
    localparam logic [2:0] KW_LAST = 3'(KW_BEATS - 1);

    if (!legalLanes(LANES)) begin : g_bad_lanes
        $error("aes_sub_sched: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [127:0] st_buf_q, st_buf_d;
    logic [4:0]   st_cnt_q, st_cnt_d;
    logic         st_active_q, st_active_d;
    logic         st_mode_q, st_mode_d;
    logic         st_done_q, st_done_d;
    logic [127:0] st_result_q, st_result_d;
    logic [31:0]  kw_buf_q, kw_buf_d;
    logic [2:0]   kw_cnt_q, kw_cnt_d;
    logic         kw_active_q, kw_active_d;
    logic         kw_done_q, kw_done_d;
    logic [31:0]  kw_result_q, kw_result_d;
    own_e         last_own_q, last_own_d;

    logic          st_beat;
    logic          kw_beat;
    logic          bank_encrypt;
    logic [BW-1:0] bank_in;
    logic [BW-1:0] bank_out;

    // Owner select: a lone active job always wins, otherwise alternate with the last beat.
    always_comb begin
        st_beat = st_active_q && (!kw_active_q || (last_own_q == OWN_KW));
        kw_beat = kw_active_q && !st_beat;
    end

    // Steer the owner's current byte group into the bank; key beats are always forward.
    always_comb begin
        bank_in      = '0;
        bank_encrypt = 1'b1;
        if (st_beat) begin
            bank_in      = st_buf_q[int'(st_cnt_q) * BW +: BW];
            bank_encrypt = st_mode_q;
        end else if (kw_beat) begin
            bank_in[KW_BW-1:0] = kw_buf_q[int'(kw_cnt_q) * KW_BW +: KW_BW];
        end
    end

    sbox_bank #(
        .LANES (LANES)
    ) u_bank (
        .encrypt_i (bank_encrypt),
        .data_i    (bank_in),
        .data_o    (bank_out)
    );

    // Next state: accept idle jobs, write back beat results, close out on the final beat.
    always_comb begin
        st_buf_d    = st_buf_q;
        st_cnt_d    = st_cnt_q;
        st_active_d = st_active_q;
        st_mode_d   = st_mode_q;
        st_done_d   = 1'b0;
        st_result_d = st_result_q;
        kw_buf_d    = kw_buf_q;
        kw_cnt_d    = kw_cnt_q;
        kw_active_d = kw_active_q;
        kw_done_d   = 1'b0;
        kw_result_d = kw_result_q;
        last_own_d  = last_own_q;

        if (!st_active_q && st_valid) begin
            st_buf_d    = st_data;
            st_cnt_d    = '0;
            st_active_d = 1'b1;
            st_mode_d   = st_encrypt;
        end else if (st_beat) begin
            st_buf_d[int'(st_cnt_q) * BW +: BW] = bank_out;
            st_cnt_d   = st_cnt_q + 5'd1;
            last_own_d = OWN_ST;
            if (st_cnt_q == ST_LAST) begin
                st_result_d = st_buf_d;
                st_active_d = 1'b0;
                st_done_d   = 1'b1;
            end
        end

        if (!kw_active_q && kw_valid) begin
            kw_buf_d    = kw_data;
            kw_cnt_d    = '0;
            kw_active_d = 1'b1;
        end else if (kw_beat) begin
            kw_buf_d[int'(kw_cnt_q) * KW_BW +: KW_BW] = bank_out[KW_BW-1:0];
            kw_cnt_d   = kw_cnt_q + 3'd1;
            last_own_d = OWN_KW;
            if (kw_cnt_q == KW_LAST) begin
                kw_result_d = kw_buf_d;
                kw_active_d = 1'b0;
                kw_done_d   = 1'b1;
            end
        end
    end

    // State registers; reset drops any job in flight and leaves the last owner as KW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_buf_q    <= '0;
            st_cnt_q    <= '0;
            st_active_q <= 1'b0;
            st_mode_q   <= 1'b1;
            st_done_q   <= 1'b0;
            st_result_q <= '0;
            kw_buf_q    <= '0;
            kw_cnt_q    <= '0;
            kw_active_q <= 1'b0;
            kw_done_q   <= 1'b0;
            kw_result_q <= '0;
            last_own_q  <= OWN_KW;
        end else begin
            st_buf_q    <= st_buf_d;
            st_cnt_q    <= st_cnt_d;
            st_active_q <= st_active_d;
            st_mode_q   <= st_mode_d;
            st_done_q   <= st_done_d;
            st_result_q <= st_result_d;
            kw_buf_q    <= kw_buf_d;
            kw_cnt_q    <= kw_cnt_d;
            kw_active_q <= kw_active_d;
            kw_done_q   <= kw_done_d;
            kw_result_q <= kw_result_d;
            last_own_q  <= last_own_d;
        end
    end

    assign st_ready  = !st_active_q;
    assign kw_ready  = !kw_active_q;
    assign st_done   = st_done_q;
    assign kw_done   = kw_done_q;
    assign st_result = st_result_q;
    assign kw_result = kw_result_q;
    assign busy      = st_active_q || kw_active_q;

endmodule

// File: tb/tb_aes_sub_sched.sv
// Directed bench for aes_sub_sched: a LANES=4 instance for the main scenarios,
// plus LANES=1 and LANES=16 instances for the bank-width sweep.
module tb_aes_sub_sched;

    typedef struct {
        string        name;
        logic [127:0] data;
        logic         enc;
        logic [127:0] result;
    } stVec_t;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [31:0] result;
    } kwVec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         stValid, stEncrypt, kwValid, sweepValid, idleKwValid;
    logic [127:0] stData;
    logic [31:0]  kwData;

    logic         stReady, stDone, kwReady, kwDone, busy;
    logic [127:0] stResult;
    logic [31:0]  kwResult;

    logic         stReady1, stDone1, kwReady1, kwDone1, busy1;
    logic [127:0] stResult1;
    logic [31:0]  kwResult1;
    logic         stReady16, stDone16, kwReady16, kwDone16, busy16;
    logic [127:0] stResult16;
    logic [31:0]  kwResult16;

    int passCount  = 0;
    int checkCount = 0;

    stVec_t stTable[4];
    kwVec_t kwTable[3];

    always #5 clk = ~clk;

    aes_sub_sched #(.LANES(4)) dut (
        .clk(clk), .rst(rst),
        .st_valid(stValid), .st_ready(stReady), .st_data(stData), .st_encrypt(stEncrypt),
        .st_done(stDone), .st_result(stResult),
        .kw_valid(kwValid), .kw_ready(kwReady), .kw_data(kwData),
        .kw_done(kwDone), .kw_result(kwResult), .busy(busy)
    );

    aes_sub_sched #(.LANES(1)) dut1 (
        .clk(clk), .rst(rst),
        .st_valid(sweepValid), .st_ready(stReady1), .st_data(stData), .st_encrypt(stEncrypt),
        .st_done(stDone1), .st_result(stResult1),
        .kw_valid(idleKwValid), .kw_ready(kwReady1), .kw_data(kwData),
        .kw_done(kwDone1), .kw_result(kwResult1), .busy(busy1)
    );

    aes_sub_sched #(.LANES(16)) dut16 (
        .clk(clk), .rst(rst),
        .st_valid(sweepValid), .st_ready(stReady16), .st_data(stData), .st_encrypt(stEncrypt),
        .st_done(stDone16), .st_result(stResult16),
        .kw_valid(idleKwValid), .kw_ready(kwReady16), .kw_data(kwData),
        .kw_done(kwDone16), .kw_result(kwResult16), .busy(busy16)
    );

    // Compare one observed value against its expectation and tally the outcome.
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // Run one state job on the LANES=4 instance and check latency, ready, result and pulse width.
    task automatic applyStimulus(input stVec_t v, input int expLat);
        int doneAt;
        logic readyAtDone;
        doneAt = -1;
        readyAtDone = 1'b0;
        @(negedge clk);
        stValid = 1'b1; stData = v.data; stEncrypt = v.enc;
        @(posedge clk); #1;
        stValid = 1'b0; stData = {$urandom, $urandom, $urandom, $urandom}; stEncrypt = ~v.enc;
        checkOutput({v.name, " ready low"}, stReady, 1'b0);
        for (int i = 1; i <= 40 && doneAt < 0; i++) begin
            @(posedge clk); #1;
            if (stDone) begin doneAt = i; readyAtDone = stReady; end
        end
        checkOutput({v.name, " latency"}, doneAt, expLat);
        checkOutput({v.name, " result"}, stResult, v.result);
        checkOutput({v.name, " ready in done"}, readyAtDone, 1'b1);
        @(posedge clk); #1;
        checkOutput({v.name, " done pulse"}, stDone, 1'b0);
        checkOutput({v.name, " result held"}, stResult, v.result);
    endtask

    // Run one key-word job alone and check latency and result.
    task automatic applyKeyWord(input kwVec_t v);
        int doneAt;
        doneAt = -1;
        @(negedge clk);
        kwValid = 1'b1; kwData = v.data;
        @(posedge clk); #1;
        kwValid = 1'b0; kwData = $urandom;
        for (int i = 1; i <= 10 && doneAt < 0; i++) begin
            @(posedge clk); #1;
            if (kwDone) doneAt = i;
        end
        checkOutput({v.name, " latency"}, doneAt, 1);
        checkOutput({v.name, " result"}, kwResult, v.result);
        @(posedge clk); #1;
        checkOutput({v.name, " done pulse"}, kwDone, 1'b0);
    endtask

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int kwAt, stAt, stPulses, d1At, d16At;

        stTable[0] = '{"fwd zero", {16{8'h00}}, 1'b1, {16{8'h63}}};
        stTable[1] = '{"inv 63", {16{8'h63}}, 1'b0, {16{8'h00}}};
        stTable[2] = '{"fwd 53", {{15{8'h00}}, 8'h53}, 1'b1, {{15{8'h63}}, 8'hED}};
        stTable[3] = '{"inv 7c", {16{8'h7C}}, 1'b0, {16{8'h01}}};
        kwTable[0] = '{"kw 03020100", 32'h03020100, 32'h7B777C63};
        kwTable[1] = '{"kw 53000001", 32'h53000001, 32'hED63637C};
        kwTable[2] = '{"kw ffffffff", 32'hFFFFFFFF, 32'h16161616};

        rst = 1'b1;
        stValid = 1'b0; stEncrypt = 1'b1; stData = '0;
        kwValid = 1'b0; kwData = '0; sweepValid = 1'b0; idleKwValid = 1'b0;
        #12;
        checkOutput("reset st_ready", stReady, 1'b1);
        checkOutput("reset kw_ready", kwReady, 1'b1);
        checkOutput("reset st_done", stDone, 1'b0);
        checkOutput("reset kw_done", kwDone, 1'b0);
        checkOutput("reset st_result", stResult, '0);
        checkOutput("reset kw_result", kwResult, '0);
        checkOutput("reset busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (stTable[i]) applyStimulus(stTable[i], 4);
        foreach (kwTable[i]) applyKeyWord(kwTable[i]);

        // Contention: both accepted on one edge, beats go ST, KW, ST, ST, ST.
        kwAt = -1; stAt = -1; stPulses = 0;
        @(negedge clk);
        stValid = 1'b1; stData = {16{8'h01}}; stEncrypt = 1'b1;
        kwValid = 1'b1; kwData = {4{8'h01}};
        @(posedge clk); #1;
        stValid = 1'b0; kwValid = 1'b0;
        checkOutput("contend busy", busy, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (kwDone && kwAt < 0) kwAt = i;
            if (stDone) begin
                stPulses++;
                if (stAt < 0) stAt = i;
            end
        end
        checkOutput("contend kw latency", kwAt, 2);
        checkOutput("contend kw result", kwResult, 32'h7C7C7C7C);
        checkOutput("contend st latency", stAt, 5);
        checkOutput("contend st result", stResult, {16{8'h7C}});
        checkOutput("contend st pulses", stPulses, 1);
        checkOutput("contend idle busy", busy, 1'b0);

        // Bank width sweep on the LANES=1 and LANES=16 instances.
        d1At = -1; d16At = -1;
        @(negedge clk);
        sweepValid = 1'b1; stData = {{15{8'h00}}, 8'h53}; stEncrypt = 1'b1;
        @(posedge clk); #1;
        sweepValid = 1'b0; stData = {$urandom, $urandom, $urandom, $urandom}; stEncrypt = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (stDone1 && d1At < 0) d1At = i;
            if (stDone16 && d16At < 0) d16At = i;
        end
        checkOutput("lanes1 latency", d1At, 16);
        checkOutput("lanes1 result", stResult1, {{15{8'h63}}, 8'hED});
        checkOutput("lanes16 latency", d16At, 1);
        checkOutput("lanes16 result", stResult16, {{15{8'h63}}, 8'hED});

        // Reset two beats into a state job: everything returns to idle, no done pulse.
        @(negedge clk);
        stValid = 1'b1; stData = {16{8'h00}}; stEncrypt = 1'b1;
        @(posedge clk); #1;
        stValid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset st_done", stDone, 1'b0);
        checkOutput("midreset st_result", stResult, '0);
        checkOutput("midreset st_ready", stReady, 1'b1);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset kw_result", kwResult, '0);
        stPulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (stDone) stPulses++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (stDone) stPulses++;
        end
        checkOutput("midreset no done", stPulses, 0);
        applyStimulus(stTable[2], 4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
